// File: rtl/qe_pkg.sv
// rtl/qe_pkg.sv - shared types, count-mode constants and Gray-step decode for the quadrature front end
package qe_pkg;

  typedef enum logic {S_SETTLE, S_RUN} qe_state_t;

  localparam int QE_X1 = 1;
  localparam int QE_X2 = 2;
  localparam int QE_X4 = 4;

  typedef struct packed {
    logic valid;
    logic dir;
    logic illegal;
  } qe_step_t;

  function automatic qe_step_t qe_step(input logic [1:0] prev, input logic [1:0] cur);
    qe_step_t   s;
    logic [1:0] diff;
    diff      = prev ^ cur;
    s.valid   = (diff == 2'b01) || (diff == 2'b10);
    s.illegal = (diff == 2'b11);
    // In every forward step ({A,B}: 00->10->11->01->00) the new A differs from the old B
    s.dir     = s.valid & (prev[0] ^ cur[1]);
    return s;
  endfunction

endpackage

// File: rtl/qe_glitch_filter.sv
// rtl/qe_glitch_filter.sv - two-flop synchroniser plus persistence filter for one encoder pin
module qe_glitch_filter #(
  parameter int FILTER_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic pin,
  output logic filtered
);

  localparam int            CW   = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(FILTER_CYCLES - 1);

  logic          meta;
  logic          synced;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta     <= 1'b0;
      synced   <= 1'b0;
      cnt      <= '0;
      filtered <= 1'b0;
    end else begin
      meta   <= pin;
      synced <= meta;
      // Any return to the accepted level restarts the persistence count
      if (synced == filtered) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        filtered <= synced;
        cnt      <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/qe_input_conditioner.sv
// rtl/qe_input_conditioner.sv - filters A/B/I pins and decodes them into count, direction and index strobes
module qe_input_conditioner
  import qe_pkg::*;
#(
  parameter int FILTER_CYCLES = 4,
  parameter int COUNT_MODE    = QE_X4,
  parameter int INDEX_GATED   = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic quad_A,
  input  logic quad_B,
  input  logic quad_I,
  input  logic error_clear,
  output logic count_pulse,
  output logic direction,
  output logic index,
  output logic qe_error,
  output logic ready
);

  localparam int            SW          = $clog2(FILTER_CYCLES + 3);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(FILTER_CYCLES + 2);

  logic          a_f, b_f, i_f;
  logic [1:0]    cur_ab, prev_ab;
  logic          prev_i;
  qe_state_t     state, state_next;
  logic [SW-1:0] settle_cnt;
  logic          settle_done;
  logic          run;
  qe_step_t      step;
  logic          pulse_hit;
  logic          index_hit;

  qe_glitch_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_filt_a (
    .clk(clk), .reset(reset), .pin(quad_A), .filtered(a_f));
  qe_glitch_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_filt_b (
    .clk(clk), .reset(reset), .pin(quad_B), .filtered(b_f));
  qe_glitch_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_filt_i (
    .clk(clk), .reset(reset), .pin(quad_I), .filtered(i_f));

  assign cur_ab = {a_f, b_f};
  assign run    = (state == S_RUN);
  assign ready  = run;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_SETTLE;
      settle_cnt <= '0;
    end else begin
      state <= state_next;
      if ((state == S_SETTLE) && !settle_done) settle_cnt <= settle_cnt + 1'b1;
    end
  end

  always_comb begin
    state_next  = state;
    settle_done = (settle_cnt == SETTLE_LAST);
    case (state)
      S_SETTLE: if (settle_done) state_next = S_RUN;
      S_RUN:    state_next = S_RUN;
      default:  state_next = S_SETTLE;
    endcase
  end

  always_comb begin
    step      = qe_step(prev_ab, cur_ab);
    pulse_hit = 1'b0;
    case (COUNT_MODE)
      QE_X1:   pulse_hit = step.valid && (step.dir ? (!prev_ab[1] && cur_ab[1])
                                                   : (prev_ab[1] && !cur_ab[1]));
      QE_X2:   pulse_hit = step.valid && (prev_ab[1] != cur_ab[1]);
      default: pulse_hit = step.valid;
    endcase
    index_hit = !prev_i && i_f && ((INDEX_GATED == 0) || (cur_ab == 2'b11));
  end

  // prev_* track filtered every cycle, so on entering S_RUN they already hold the settled pins
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_ab     <= 2'b00;
      prev_i      <= 1'b0;
      count_pulse <= 1'b0;
      direction   <= 1'b0;
      index       <= 1'b0;
      qe_error    <= 1'b0;
    end else begin
      prev_ab     <= cur_ab;
      prev_i      <= i_f;
      count_pulse <= run && enable && pulse_hit;
      index       <= run && enable && index_hit;
      if (run && step.valid) direction <= step.dir;
      if (run && step.illegal) qe_error <= 1'b1;
      else if (error_clear)   qe_error <= 1'b0;
    end
  end

endmodule

// File: tb/tb_qe_input_conditioner.sv
// tb/tb_qe_input_conditioner.sv - directed checks of filtering, decode modes, index gating and error handling
module tb_qe_input_conditioner;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic enable = 1'b1;
  logic quad_A = 1'b1;
  logic quad_B = 1'b1;
  logic quad_I = 1'b0;
  logic error_clear = 1'b0;

  logic cp4, dir4, idx4, err4, rdy4;
  logic cp2, dir2, idx2, err2, rdy2;
  logic cp1, dir1, idx1, err1, rdy1;

  int vectors = 0;
  int miscompares = 0;
  int n_cp4 = 0, n_cp2 = 0, n_cp1 = 0, n_idx4 = 0, n_idx2 = 0;

  always #5 clk = ~clk;

  qe_input_conditioner #(.FILTER_CYCLES(4), .COUNT_MODE(4), .INDEX_GATED(1)) dut4 (
    .clk(clk), .reset(reset), .enable(enable), .quad_A(quad_A), .quad_B(quad_B),
    .quad_I(quad_I), .error_clear(error_clear), .count_pulse(cp4), .direction(dir4),
    .index(idx4), .qe_error(err4), .ready(rdy4));

  qe_input_conditioner #(.FILTER_CYCLES(4), .COUNT_MODE(2), .INDEX_GATED(0)) dut2 (
    .clk(clk), .reset(reset), .enable(enable), .quad_A(quad_A), .quad_B(quad_B),
    .quad_I(quad_I), .error_clear(error_clear), .count_pulse(cp2), .direction(dir2),
    .index(idx2), .qe_error(err2), .ready(rdy2));

  qe_input_conditioner #(.FILTER_CYCLES(4), .COUNT_MODE(1), .INDEX_GATED(1)) dut1 (
    .clk(clk), .reset(reset), .enable(enable), .quad_A(quad_A), .quad_B(quad_B),
    .quad_I(quad_I), .error_clear(error_clear), .count_pulse(cp1), .direction(dir1),
    .index(idx1), .qe_error(err1), .ready(rdy1));

  always @(negedge clk) begin
    if (cp4)  n_cp4++;
    if (cp2)  n_cp2++;
    if (cp1)  n_cp1++;
    if (idx4) n_idx4++;
    if (idx2) n_idx2++;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive(input logic a, input logic b, input int n);
    quad_A = a;
    quad_B = b;
    tick(n);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    int b4, b2, b1, bi4, bi2;
    logic [1:0] fwd [4];
    fwd = '{2'b10, 2'b11, 2'b01, 2'b00};

    // Reset and settle with pins parked at A=B=1
    tick(1);
    check("reset_ready", rdy4, 0);
    check("reset_dir", dir4, 0);
    check("reset_pulse", cp4, 0);
    tick(2);
    reset = 1'b0;
    tick(6);
    check("settle_not_ready", rdy4, 0);
    tick(1);
    check("ready_after_7", rdy4, 1);
    check("ready_after_7_x1", rdy1, 1);
    check("settle_no_error", err4, 0);
    check("settle_no_pulse", n_cp4, 0);

    // Forward full cycle, exact latency and width on the x4 instance
    drive(1'b0, 1'b1, 10);
    drive(1'b0, 1'b0, 10);
    b4 = n_cp4; b2 = n_cp2; b1 = n_cp1;
    for (int k = 0; k < 4; k++) begin
      {quad_A, quad_B} = fwd[k];
      tick(6);
      check("fwd_early", cp4, 0);
      tick(1);
      check("fwd_pulse", cp4, 1);
      check("fwd_dir", dir4, 1);
      tick(1);
      check("fwd_one_wide", cp4, 0);
      tick(2);
    end
    check("fwd_x4_count", n_cp4 - b4, 4);
    check("fwd_x2_count", n_cp2 - b2, 2);
    check("fwd_x1_count", n_cp1 - b1, 1);

    // Reverse full cycle
    b4 = n_cp4; b2 = n_cp2; b1 = n_cp1;
    drive(1'b0, 1'b1, 10);
    check("rev_dir_first", dir4, 0);
    drive(1'b1, 1'b1, 10);
    drive(1'b1, 1'b0, 10);
    drive(1'b0, 1'b0, 10);
    check("rev_x4_count", n_cp4 - b4, 4);
    check("rev_x2_count", n_cp2 - b2, 2);
    check("rev_x1_count", n_cp1 - b1, 1);
    check("rev_dir_x2", dir2, 0);
    check("rev_dir_x1", dir1, 0);

    // Glitches on A: 3 cycles rejected, 4 cycles accepted
    b4 = n_cp4;
    quad_A = 1'b1; tick(3); quad_A = 1'b0; tick(10);
    check("glitch3_no_pulse", n_cp4 - b4, 0);
    check("glitch3_dir_held", dir4, 0);
    quad_A = 1'b1; tick(4); quad_A = 1'b0; tick(3);
    check("glitch4_pulse", cp4, 1);
    check("glitch4_dir_fwd", dir4, 1);
    tick(10);
    check("glitch4_count", n_cp4 - b4, 2);
    check("glitch4_dir_rev", dir4, 0);

    // Illegal double-bit step, clear, and set-beats-clear
    b4 = n_cp4;
    drive(1'b1, 1'b1, 10);
    check("illegal_error", err4, 1);
    check("illegal_no_pulse", n_cp4 - b4, 0);
    check("illegal_dir_held", dir4, 0);
    error_clear = 1'b1; tick(1); error_clear = 1'b0;
    check("error_cleared", err4, 0);
    quad_A = 1'b0; quad_B = 1'b0;
    tick(6);
    error_clear = 1'b1; tick(1); error_clear = 1'b0;
    check("set_beats_clear", err4, 1);
    tick(3);
    error_clear = 1'b1; tick(1); error_clear = 1'b0;
    check("error_cleared_again", err4, 0);

    // Index gating
    drive(1'b1, 1'b0, 10);
    drive(1'b1, 1'b1, 10);
    quad_I = 1'b1;
    tick(6);
    check("index_early", idx4, 0);
    tick(1);
    check("index_strobe", idx4, 1);
    tick(1);
    check("index_one_wide", idx4, 0);
    quad_I = 1'b0; tick(10);
    drive(1'b0, 1'b1, 10);
    bi4 = n_idx4; bi2 = n_idx2;
    quad_I = 1'b1; tick(10);
    check("index_gated_off", n_idx4 - bi4, 0);
    check("index_ungated", n_idx2 - bi2, 1);
    quad_I = 1'b0; tick(10);

    // enable=0 masks strobes but direction still tracks
    enable = 1'b0;
    b4 = n_cp4; bi4 = n_idx4;
    drive(1'b1, 1'b1, 10);
    check("disabled_dir_rev", dir4, 0);
    quad_I = 1'b1; tick(10);
    check("disabled_no_index", n_idx4 - bi4, 0);
    drive(1'b0, 1'b1, 10);
    check("disabled_dir_fwd", dir4, 1);
    check("disabled_no_pulse", n_cp4 - b4, 0);
    quad_I = 1'b0; enable = 1'b1; tick(10);

    // Reset mid-operation reruns settle
    reset = 1'b1;
    #1;
    check("midreset_ready", rdy4, 0);
    check("midreset_dir", dir4, 0);
    tick(2);
    reset = 1'b0;
    tick(6);
    check("resettle_not_ready", rdy4, 0);
    tick(1);
    check("resettle_ready", rdy4, 1);
    check("resettle_no_error", err4, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
